// File: rtl/sprite_animator.sv
// Pipelined sprite renderer: one SPR_W x SPR_H sprite, power-of-two scale, h-flip,
// multi-frame animation from an external synchronous ROM; 3-cycle pixel latency.
module sprite_animator #(
  parameter int SPR_W       = 196,
  parameter int SPR_H       = 96,
  parameter int NUM_FRAMES  = 4,
  parameter int FRAME_TICKS = 8,
  parameter int IDX_W       = 3,
  parameter int TRANSP_IDX  = 0,
  parameter int ADDR_W      = $clog2(SPR_W*SPR_H*NUM_FRAMES),
  localparam int CF_W       = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_start,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic [1:0]        scale,
  input  logic              flip_h,
  input  logic              anim_en,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pix_index,
  output logic              pix_opaque,
  output logic [CF_W-1:0]   cur_frame
);

  localparam int FRAME_PIX = SPR_W * SPR_H;
  localparam int TICK_W    = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int LIM_W     = 16;

  logic [9:0]        sh_x, sh_y;
  logic [1:0]        sh_scale;
  logic              sh_flip;
  logic [TICK_W-1:0] tick;

  logic              hit1, blank1, hit2, blank2;

  // Shadow registers and animation counters change only at frame_start, so a
  // frame is always drawn with one consistent configuration.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      sh_x      <= '0;
      sh_y      <= '0;
      sh_scale  <= '0;
      sh_flip   <= 1'b0;
      tick      <= '0;
      cur_frame <= '0;
    end else if (frame_start) begin
      sh_x     <= pos_x;
      sh_y     <= pos_y;
      sh_scale <= scale;
      sh_flip  <= flip_h;
      if (anim_en) begin
        if (tick == TICK_W'(FRAME_TICKS - 1)) begin
          tick <= '0;
          if (cur_frame == CF_W'(NUM_FRAMES - 1))
            cur_frame <= '0;
          else
            cur_frame <= cur_frame + 1'b1;
        end else begin
          tick <= tick + 1'b1;
        end
      end
    end
  end

  logic [10:0]       rx, ry;
  logic [LIM_W-1:0]  w_lim, h_lim;
  logic              hit;
  logic [9:0]        sx_raw, sx, sy;
  logic [ADDR_W-1:0] addr;

  // 11-bit signed offsets; bit 10 set means the pixel is left of / above the sprite.
  assign rx    = {1'b0, DrawX} - {1'b0, sh_x};
  assign ry    = {1'b0, DrawY} - {1'b0, sh_y};
  assign w_lim = LIM_W'(SPR_W) << sh_scale;
  assign h_lim = LIM_W'(SPR_H) << sh_scale;

  assign hit = ~rx[10] & ~ry[10]
             & (LIM_W'(rx[9:0]) < w_lim)
             & (LIM_W'(ry[9:0]) < h_lim);

  assign sx_raw = rx[9:0] >> sh_scale;
  assign sy     = ry[9:0] >> sh_scale;
  assign sx     = sh_flip ? (10'(SPR_W - 1) - sx_raw) : sx_raw;

  always_comb begin
    addr = '0;
    if (hit)
      addr = ADDR_W'(cur_frame) * ADDR_W'(FRAME_PIX)
           + ADDR_W'(sy) * ADDR_W'(SPR_W)
           + ADDR_W'(sx);
  end

  // Stage 1 issues the ROM address, stage 2 waits on the ROM, stage 3 resolves
  // transparency. hit/blank travel alongside so they line up with rom_q.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rom_address <= '0;
      hit1        <= 1'b0;
      blank1      <= 1'b0;
      hit2        <= 1'b0;
      blank2      <= 1'b0;
      pix_index   <= '0;
      pix_opaque  <= 1'b0;
    end else begin
      rom_address <= addr;
      hit1        <= hit;
      blank1      <= blank;
      hit2        <= hit1;
      blank2      <= blank1;
      pix_index   <= hit2 ? rom_q : IDX_W'(TRANSP_IDX);
      pix_opaque  <= hit2 & blank2 & (rom_q != IDX_W'(TRANSP_IDX));
    end
  end

endmodule

// File: tb/tb_sprite_animator.sv
// Directed bench for sprite_animator: table of placement/flip/scale/blank vectors
// plus hand sequences for animation, shadow timing and mid-sprite reset.
module tb_sprite_animator;

  logic        vga_clk = 1'b0;
  logic        reset;
  logic [9:0]  DrawX, DrawY, pos_x, pos_y;
  logic        blank, frame_start, flip_h, anim_en;
  logic [1:0]  scale;
  logic [16:0] rom_address;
  logic [2:0]  rom_q;
  logic [2:0]  pix_index;
  logic        pix_opaque;
  logic [1:0]  cur_frame;
  logic [2:0]  rom_fill;

  int n_vec = 0;
  int n_err = 0;

  always #5 vga_clk = ~vga_clk;

  // Synchronous ROM model: every word holds rom_fill, one cycle read latency.
  always @(posedge vga_clk) rom_q <= rom_fill;

  sprite_animator dut (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y), .scale(scale),
    .flip_h(flip_h), .anim_en(anim_en), .rom_address(rom_address), .rom_q(rom_q),
    .pix_index(pix_index), .pix_opaque(pix_opaque), .cur_frame(cur_frame)
  );

  typedef struct {
    string name;
    int px, py, sc, fl;
    int x, y, b, rom;
    int exp_hit, exp_addr;
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fs_pulse();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
  endtask

  task automatic set_cfg(input int px, input int py, input int sc, input int fl);
    pos_x = 10'(px); pos_y = 10'(py); scale = 2'(sc); flip_h = fl[0];
    fs_pulse();
  endtask

  task automatic pixel(input int x, input int y, input int b);
    DrawX = 10'(x); DrawY = 10'(y); blank = b[0];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //            name        px  py sc fl   x    y   b rom hit addr
    vecs.push_back('{"tl",      100, 50,0,0, 100, 50, 1, 5, 1, 0});
    vecs.push_back('{"right",   100, 50,0,0, 295, 50, 1, 5, 1, 195});
    vecs.push_back('{"r_miss",  100, 50,0,0, 296, 50, 1, 5, 0, 0});
    vecs.push_back('{"l_miss",  100, 50,0,0,  99, 50, 1, 5, 0, 0});
    vecs.push_back('{"bottom",  100, 50,0,0, 100,145, 1, 5, 1, 18620});
    vecs.push_back('{"b_miss",  100, 50,0,0, 100,146, 1, 5, 0, 0});
    vecs.push_back('{"flip_l",  100, 50,0,1, 100, 50, 1, 5, 1, 195});
    vecs.push_back('{"flip_r",  100, 50,0,1, 295, 50, 1, 5, 1, 0});
    vecs.push_back('{"flip_in", 100, 50,0,1, 101, 51, 1, 5, 1, 390});
    vecs.push_back('{"sc1",     100, 50,1,0, 103, 53, 1, 5, 1, 197});
    vecs.push_back('{"sc1_r",   100, 50,1,0, 491, 50, 1, 5, 1, 195});
    vecs.push_back('{"sc1_miss",100, 50,1,0, 492, 50, 1, 5, 0, 0});
    vecs.push_back('{"sc1_flip",100, 50,1,1, 103, 53, 1, 5, 1, 390});
    vecs.push_back('{"sc2",      10, 20,2,0,  33, 28, 1, 5, 1, 397});
    vecs.push_back('{"clip",    600,400,0,0, 639,479, 1, 5, 1, 15523});
    vecs.push_back('{"neg_rx",  500,  0,0,0,  10,  5, 1, 5, 0, 0});
    vecs.push_back('{"transp",  100, 50,0,0, 100, 50, 1, 0, 1, 0});
    vecs.push_back('{"blank0",  100, 50,0,0, 100, 50, 0, 5, 1, 0});

    reset = 1'b1; frame_start = 1'b0; anim_en = 1'b0; rom_fill = 3'd5;
    pos_x = '0; pos_y = '0; scale = '0; flip_h = 1'b0;
    pixel(0, 0, 0);
    step(); step();
    chk("rst_addr",   int'(rom_address), 0);
    chk("rst_opaque", int'(pix_opaque), 0);
    chk("rst_index",  int'(pix_index), 0);
    chk("rst_frame",  int'(cur_frame), 0);
    reset = 1'b0;
    step();

    foreach (vecs[i]) begin
      vec_t v;
      int exp_op, exp_idx;
      v = vecs[i];
      rom_fill = 3'(v.rom);
      set_cfg(v.px, v.py, v.sc, v.fl);
      pixel(v.x, v.y, v.b);
      step();
      chk({v.name, "_addr"}, int'(rom_address), v.exp_addr);
      step(); step();
      exp_op  = (v.exp_hit != 0 && v.b != 0 && v.rom != 0) ? 1 : 0;
      exp_idx = (v.exp_hit != 0) ? v.rom : 0;
      chk({v.name, "_opaque"}, int'(pix_opaque), exp_op);
      chk({v.name, "_index"},  int'(pix_index), exp_idx);
    end

    // Shadow registers: mid-frame pos_x change is ignored until frame_start.
    rom_fill = 3'd5;
    set_cfg(100, 50, 0, 0);
    pos_x = 10'd300;
    pixel(100, 50, 1);
    step(); step(); step();
    chk("shadow_old_hit", int'(pix_opaque), 1);
    pixel(300, 50, 1);
    step(); step(); step();
    chk("shadow_new_miss", int'(pix_opaque), 0);
    fs_pulse();
    step(); step(); step();
    chk("shadow_new_hit", int'(pix_opaque), 1);
    chk("shadow_new_addr", int'(rom_address), 0);

    // Animation: 8 enabled pulses per frame step, wrap after 4 frames.
    pixel(0, 0, 0);
    pos_x = 10'd100; pos_y = 10'd50;
    anim_en = 1'b1;
    for (int k = 0; k < 7; k++) fs_pulse();
    chk("anim_7", int'(cur_frame), 0);
    fs_pulse();
    chk("anim_8", int'(cur_frame), 1);
    pixel(100, 50, 1);
    step();
    chk("anim_addr", int'(rom_address), 18816);
    pixel(0, 0, 0);
    anim_en = 1'b0;
    for (int k = 0; k < 10; k++) fs_pulse();
    chk("anim_hold", int'(cur_frame), 1);
    anim_en = 1'b1;
    for (int k = 0; k < 8; k++) fs_pulse();
    chk("anim_16", int'(cur_frame), 2);
    for (int k = 0; k < 8; k++) fs_pulse();
    chk("anim_24", int'(cur_frame), 3);
    for (int k = 0; k < 8; k++) fs_pulse();
    chk("anim_32_wrap", int'(cur_frame), 0);

    // Mid-sprite reset: outputs and frame clear at once; opaque returns 3 cycles later.
    for (int k = 0; k < 8; k++) fs_pulse();
    anim_en = 1'b0;
    chk("pre_rst_frame", int'(cur_frame), 1);
    pixel(100, 50, 1);
    step(); step(); step();
    chk("pre_rst_opaque", int'(pix_opaque), 1);
    reset = 1'b1;
    step();
    chk("rst_mid_opaque", int'(pix_opaque), 0);
    chk("rst_mid_frame",  int'(cur_frame), 0);
    chk("rst_mid_addr",   int'(rom_address), 0);
    reset = 1'b0;
    step();
    chk("post_rst_1", int'(pix_opaque), 0);
    step();
    chk("post_rst_2", int'(pix_opaque), 0);
    step();
    chk("post_rst_3", int'(pix_opaque), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
